// File: rtl/vec3_dot_mac.sv
// -----------------------------------------------------------------------------
// vec3_dot_mac
//
// Fixed-point dot-product engine for the QR datapath. Requests a vector pair
// from two upstream column buffers, multiplies and accumulates each element pair
// at full precision, then rounds half-up and saturates the sum back to the
// datapath width.
//
// Parameters
//   DATA_WIDTH  signed width of operands and result
//   FRAC_BITS   fractional bits of the Q format (1 <= FRAC_BITS < DATA_WIDTH)
//   VEC_LEN     elements per vector (>= 1)
//
// Ports
//   clk       single clock, rising edge
//   reset     synchronous, active-high reset
//   start     level request, held high for the whole operation
//   a_i, b_i  signed element pair
//   in_valid  a_i/b_i valid this cycle (sampled only in REQ)
//   rd_req    read request to both upstream buffers
//   busy      high in REQ and ROUND
//   done      result valid (DONE state)
//   dot_o     rounded, saturated dot product
//   sat       last result was clipped
// -----------------------------------------------------------------------------
module vec3_dot_mac #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int VEC_LEN    = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   input  logic                         in_valid,
   output logic                         rd_req,
   output logic                         busy,
   output logic                         done,
   output logic signed [DATA_WIDTH-1:0] dot_o,
   output logic                         sat
);

   localparam int PROD_W = 2 * DATA_WIDTH;
   // Two guard bits cover up to four products; longer vectors need more.
   localparam int ACC_W  = 2 * DATA_WIDTH + 2 + ((VEC_LEN > 4) ? $clog2(VEC_LEN) : 0);
   localparam int CNT_W  = $clog2(VEC_LEN + 1);

   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(VEC_LEN - 1);
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) << (DATA_WIDTH - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = -(ACC_W'(1) << (DATA_WIDTH - 1));

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_ROUND,
      ST_DONE
   } state_t;

   state_t                         state_q, state_d;
   logic signed [ACC_W-1:0]        acc_q,   acc_d;
   logic        [CNT_W-1:0]        cnt_q,   cnt_d;
   logic signed [DATA_WIDTH-1:0]   dot_q,   dot_d;
   logic                           sat_q,   sat_d;

   logic signed [PROD_W-1:0]       prod;
   logic signed [ACC_W-1:0]        prod_ext;
   logic signed [ACC_W-1:0]        rnd_sum;
   logic signed [ACC_W-1:0]        rnd;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      dot_d   = dot_q;
      sat_d   = sat_q;
      rd_req  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;

      // Full-precision product, sign-extended to the accumulator width.
      prod     = a_i * b_i;
      prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

      // Round half-up: add half an LSB of the output, then arithmetic shift.
      rnd_sum = acc_q + RND_HALF;
      rnd     = rnd_sum >>> FRAC_BITS;

      unique case (state_q)
         ST_IDLE: begin
            acc_d = '0;
            cnt_d = '0;
            if (start) begin
               state_d = ST_REQ;
            end
         end

         ST_REQ: begin
            rd_req = 1'b1;
            busy   = 1'b1;
            // Dropping start aborts the run even on the cycle of the last pair.
            if (!start) begin
               state_d = ST_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end else if (in_valid) begin
               acc_d = acc_q + prod_ext;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_ROUND;
               end
            end
         end

         ST_ROUND: begin
            busy    = 1'b1;
            state_d = ST_DONE;
            if (rnd > SAT_MAX) begin
               dot_d = SAT_MAX[DATA_WIDTH-1:0];
               sat_d = 1'b1;
            end else if (rnd < SAT_MIN) begin
               dot_d = SAT_MIN[DATA_WIDTH-1:0];
               sat_d = 1'b1;
            end else begin
               dot_d = rnd[DATA_WIDTH-1:0];
               sat_d = 1'b0;
            end
         end

         ST_DONE: begin
            done = 1'b1;
            if (!start) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         dot_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         dot_q   <= dot_d;
         sat_q   <= sat_d;
      end
   end

   assign dot_o = dot_q;
   assign sat   = sat_q;

endmodule

// File: tb/tb_vec3_dot_mac.sv
// -----------------------------------------------------------------------------
// tb_vec3_dot_mac
//
// Self-checking bench for vec3_dot_mac (DATA_WIDTH=16, FRAC_BITS=8, VEC_LEN=3).
// Expected results come from a behavioural model and are queued when a run's
// last pair is driven; a monitor pops and compares on each rising done.
// -----------------------------------------------------------------------------
module tb_vec3_dot_mac;

   localparam int DW = 16;
   localparam int FB = 8;

   typedef logic [2:0][DW-1:0] vec_t;

   typedef struct packed {
      logic [DW-1:0] dot;
      logic          sat;
   } exp_t;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic signed [DW-1:0] a_i;
   logic signed [DW-1:0] b_i;
   logic                 in_valid;
   logic                 rd_req;
   logic                 busy;
   logic                 done;
   logic signed [DW-1:0] dot_o;
   logic                 sat;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb_q[$];
   exp_t last_exp = '0;
   logic done_prev = 1'b0;

   vec3_dot_mac #(
      .DATA_WIDTH (DW),
      .FRAC_BITS  (FB),
      .VEC_LEN    (3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a_i      (a_i),
      .b_i      (b_i),
      .in_valid (in_valid),
      .rd_req   (rd_req),
      .busy     (busy),
      .done     (done),
      .dot_o    (dot_o),
      .sat      (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input vec_t a, input vec_t b);
      longint acc;
      longint r;
      exp_t   e;
      acc = 0;
      for (int i = 0; i < 3; i++) begin
         acc += longint'(signed'(a[i])) * longint'(signed'(b[i]));
      end
      r = (acc + (64'sd1 <<< (FB - 1))) >>> FB;
      if (r > 32767) begin
         e.dot = 16'h7FFF;
         e.sat = 1'b1;
      end else if (r < -32768) begin
         e.dot = 16'h8000;
         e.sat = 1'b1;
      end else begin
         e.dot = r[DW-1:0];
         e.sat = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard monitor: compare on every rising edge of done.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'(1'b0));
            end else begin
               e = sb_q.pop_front();
               check("dot_o", 32'(dot_o[DW-1:0]), 32'(e.dot));
               check("sat", 32'(sat), 32'(e.sat));
            end
         end
         done_prev = done;
      end
   end

   // One full operation. gap idle cycles precede each pair; drop_round lowers
   // start during ROUND; rst_round pulses reset during ROUND instead.
   task automatic run_op(input vec_t a, input vec_t b, input int gap,
                         input bit drop_round, input bit rst_round);
      exp_t e;
      int   edges;
      e = model(a, b);

      // Junk pair while IDLE must not leak into the sum.
      in_valid = 1'b1;
      a_i      = 16'h1234;
      b_i      = 16'h4321;
      start    = 1'b1;
      @(posedge clk); #1;   // edge e: start sampled
      edges = 0;
      check("rd_req_on", 32'(rd_req), 32'(1'b1));
      check("busy_on", 32'(busy), 32'(1'b1));

      for (int i = 0; i < 3; i++) begin
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            a_i      = 16'($urandom);
            b_i      = 16'($urandom);
            @(posedge clk); #1;
            edges++;
            check("rd_req_gap", 32'(rd_req), 32'(1'b1));
         end
         in_valid = 1'b1;
         a_i      = a[i];
         b_i      = b[i];
         @(posedge clk); #1;
         edges++;
         if (i < 2) check("rd_req_mid", 32'(rd_req), 32'(1'b1));
      end

      // ROUND cycle: inputs here must be ignored.
      a_i = 16'h7FFF;
      b_i = 16'h7FFF;
      check("rd_req_round", 32'(rd_req), 32'(1'b0));
      check("busy_round", 32'(busy), 32'(1'b1));
      check("done_round", 32'(done), 32'(1'b0));

      if (rst_round) begin
         reset = 1'b1;
         @(posedge clk); #1;
         reset    = 1'b0;
         start    = 1'b0;
         in_valid = 1'b0;
         check("rst_dot", 32'(dot_o[DW-1:0]), 32'h0);
         check("rst_sat", 32'(sat), 32'h0);
         check("rst_done", 32'(done), 32'h0);
         check("rst_busy", 32'(busy), 32'h0);
         check("rst_rd_req", 32'(rd_req), 32'h0);
         last_exp = '0;
         @(posedge clk); #1;
         return;
      end

      if (drop_round) start = 1'b0;
      sb_q.push_back(e);
      last_exp = e;
      @(posedge clk); #1;
      edges++;
      in_valid = 1'b0;

      for (int t = 0; t < 20 && !done; t++) begin
         @(posedge clk); #1;
         edges++;
      end
      check("done_seen", 32'(done), 32'(1'b1));
      // done is first high after edge e+4 (cycle e+5), plus any gap cycles.
      check("done_latency", 32'(edges), 32'(4 + 3 * gap));
      check("busy_done", 32'(busy), 32'(1'b0));
      check("rd_req_done", 32'(rd_req), 32'(1'b0));

      if (!drop_round) begin
         @(posedge clk); #1;
         check("done_hold", 32'(done), 32'(1'b1));
         start = 1'b0;
      end
      @(posedge clk); #1;
      check("done_exit", 32'(done), 32'(1'b0));
      @(posedge clk); #1;
   endtask

   task automatic run_abort(input vec_t a, input vec_t b);
      start    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         a_i      = a[i];
         b_i      = b[i];
         @(posedge clk); #1;
      end
      // Drop start while a third pair is offered: abort must win.
      start = 1'b0;
      a_i   = a[2];
      b_i   = b[2];
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("abort_busy", 32'(busy), 32'(1'b0));
      check("abort_rd_req", 32'(rd_req), 32'(1'b0));
      for (int t = 0; t < 4; t++) begin
         check("abort_no_done", 32'(done), 32'(1'b0));
         @(posedge clk); #1;
      end
      check("abort_dot_kept", 32'(dot_o[DW-1:0]), 32'(last_exp.dot));
      check("abort_sat_kept", 32'(sat), 32'(last_exp.sat));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t va, vb;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      a_i      = '0;
      b_i      = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd_req", 32'(rd_req), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      check("reset_dot", 32'(dot_o[DW-1:0]), 32'h0);
      check("reset_sat", 32'(sat), 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic: expect 0x0600.
      run_op({16'h0300, 16'h0200, 16'h0100}, {16'h0100, 16'h0100, 16'h0100}, 0, 1'b0, 1'b0);
      // Negative: expect 0xFA00.
      run_op({16'hFF00, 16'hFF00, 16'hFF00}, {16'h0300, 16'h0200, 16'h0100}, 0, 1'b0, 1'b0);
      // Positive saturation.
      run_op({16'h7F00, 16'h7F00, 16'h7F00}, {16'h7F00, 16'h7F00, 16'h7F00}, 0, 1'b0, 1'b0);
      // Negative saturation.
      run_op({16'h8000, 16'h8000, 16'h8000}, {16'h7F00, 16'h7F00, 16'h7F00}, 0, 1'b0, 1'b0);
      // Rounding boundary: 128 -> 1, 127 -> 0.
      run_op({16'h0000, 16'h0000, 16'h0001}, {16'h0000, 16'h0000, 16'd128}, 0, 1'b0, 1'b0);
      run_op({16'h0000, 16'h0000, 16'h0001}, {16'h0000, 16'h0000, 16'd127}, 0, 1'b0, 1'b0);
      // Negative rounding: -129 -> -1, -128 -> 0.
      run_op({16'h0000, 16'h0000, 16'hFFFF}, {16'h0000, 16'h0000, 16'd129}, 0, 1'b0, 1'b0);
      run_op({16'h0000, 16'h0000, 16'hFFFF}, {16'h0000, 16'h0000, 16'd128}, 0, 1'b0, 1'b0);
      // Gaps of 2 idle cycles, and start dropped during ROUND.
      run_op({16'h0300, 16'h0200, 16'h0100}, {16'h0100, 16'h0100, 16'h0100}, 2, 1'b0, 1'b0);
      run_op({16'h0010, 16'hF800, 16'h0123}, {16'h0400, 16'h0050, 16'hFE00}, 1, 1'b1, 1'b0);

      // Abort after 2 pairs, then a fresh run.
      run_abort({16'h7F00, 16'h7F00, 16'h7F00}, {16'h7F00, 16'h7F00, 16'h7F00});
      run_op({16'hFF00, 16'hFF00, 16'hFF00}, {16'h0300, 16'h0200, 16'h0100}, 0, 1'b0, 1'b0);

      // Reset during ROUND.
      run_op({16'h0300, 16'h0200, 16'h0100}, {16'h0100, 16'h0100, 16'h0100}, 0, 1'b0, 1'b1);
      run_op({16'h0300, 16'h0200, 16'h0100}, {16'h0100, 16'h0100, 16'h0100}, 0, 1'b0, 1'b0);

      // Random vectors.
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 3; i++) begin
            va[i] = 16'($urandom);
            vb[i] = (n < 3) ? 16'($signed(16'($urandom_range(0, 1023))) - 16'sd512) : 16'($urandom);
         end
         run_op(va, vb, int'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      repeat (2) @(posedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
